// File: rtl/ad56x3_spi_tx.sv
// ad56x3_spi_tx: serialises Avalon-ST DAC samples into 24-bit AD56x3 SPI write frames.
// After every reset it can first send the internal-reference enable frame.
module ad56x3_spi_tx #(
    parameter int SCLK_DIV   = 1,
    parameter int GAP_CYCLES = 2,
    parameter int DATA_WIDTH = 14,
    parameter int INIT_REF   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  asiValid,
    input  logic                  asiChannel,
    input  logic [DATA_WIDTH-1:0] asiData,
    output logic                  asiRdy,
    output logic                  sclk,
    output logic                  syncN,
    output logic                  din
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [23:0]      INIT_FRAME = 24'h380001;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_SHIFT,
        ST_GAP,
        ST_IDLE
    } state_t;

    state_t           r_state;
    logic [22:0]      r_shift;
    logic [DIV_W-1:0] r_divCnt;
    logic [5:0]       r_halfCnt;
    logic [GAP_W-1:0] r_gapCnt;

    logic [15:0]      w_payload;
    logic [23:0]      w_sampleFrame;

    // Samples are left-justified in the 16-bit payload; the DAC ignores the low bits.
    assign w_payload     = 16'(asiData) << (16 - DATA_WIDTH);
    assign w_sampleFrame = {5'b00011, 2'b00, asiChannel, w_payload};

    // r_shift holds the bits not yet on din, so bit 22 is always the next one out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_shift   <= '0;
            r_divCnt  <= '0;
            r_halfCnt <= '0;
            r_gapCnt  <= '0;
            asiRdy    <= 1'b0;
            sclk      <= 1'b1;
            syncN     <= 1'b1;
            din       <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_divCnt  <= '0;
                    r_halfCnt <= '0;
                    if (INIT_REF != 0) begin
                        r_shift <= INIT_FRAME[22:0];
                        din     <= INIT_FRAME[23];
                        syncN   <= 1'b0;
                        r_state <= ST_SHIFT;
                    end else begin
                        asiRdy  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (asiValid && asiRdy) begin
                        r_shift   <= w_sampleFrame[22:0];
                        din       <= w_sampleFrame[23];
                        syncN     <= 1'b0;
                        asiRdy    <= 1'b0;
                        r_divCnt  <= '0;
                        r_halfCnt <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (r_divCnt == DIV_LAST) begin
                        r_divCnt  <= '0;
                        r_halfCnt <= r_halfCnt + 6'd1;
                        // An even count here closes an odd half-period: falling edge.
                        if (!r_halfCnt[0]) begin
                            sclk <= 1'b0;
                        end else if (r_halfCnt == 6'd47) begin
                            sclk     <= 1'b1;
                            syncN    <= 1'b1;
                            din      <= 1'b0;
                            r_gapCnt <= '0;
                            r_state  <= ST_GAP;
                        end else begin
                            sclk    <= 1'b1;
                            din     <= r_shift[22];
                            r_shift <= {r_shift[21:0], 1'b0};
                        end
                    end else begin
                        r_divCnt <= r_divCnt + DIV_W'(1);
                    end
                end

                ST_GAP: begin
                    if (r_gapCnt == GAP_LAST) begin
                        asiRdy  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + GAP_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
